// File: rtl/video_write_queue_if.sv
// CPU-side iomem bus and the replayed video-port write bus of the video write queue.
interface video_write_queue_if;
  logic        cpu_valid;
  logic        cpu_ready;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic [31:0] cpu_rdata;
  logic        iomem_valid;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [3:0]  iomem_wstrb;

  modport slave (
    input  cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
    output cpu_ready, cpu_rdata,
    output iomem_valid, iomem_addr, iomem_wdata, iomem_wstrb
  );

  modport master (
    output cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
    input  cpu_ready, cpu_rdata,
    input  iomem_valid, iomem_addr, iomem_wdata, iomem_wstrb
  );
endinterface

// File: rtl/video_write_queue.sv
// Buffers CPU writes to the video peripheral in a FIFO and replays them one per cycle,
// either immediately or only during vertical sync; slot F holds status/control.
module video_write_queue #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              vga_vsync,
  video_write_queue_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [23:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            defer;

  logic            is_ctrl;
  logic            is_write;
  logic            full;
  logic            empty;
  logic            drain_en;
  logic            accept;
  logic            push;
  logic            pop;
  logic            ctrl_wr;
  logic            flush;
  logic [31:0]     status;
  entry_t          new_entry;
  entry_t          head;
  logic            unused_addr_hi;

  assign is_ctrl  = (bus.cpu_addr[23:20] == 4'hF);
  assign is_write = |bus.cpu_wstrb;
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign drain_en = !defer || !vga_vsync;

  // Full is judged on the pre-edge count, so a stalled write waits one extra cycle after a pop.
  assign accept  = bus.cpu_valid && !bus.cpu_ready && (is_ctrl || !is_write || !full);
  assign push    = accept && !is_ctrl && is_write;
  assign pop     = !empty && drain_en;
  assign ctrl_wr = accept && is_ctrl && bus.cpu_wstrb[0];
  assign flush   = ctrl_wr && bus.cpu_wdata[1];

  assign status = {16'h0, 8'(count), 4'h0, drain_en, full, empty, defer};

  assign new_entry = '{addr: bus.cpu_addr[23:0], data: bus.cpu_wdata, strb: bus.cpu_wstrb};
  assign head      = mem[rd_ptr];

  assign unused_addr_hi = ^bus.cpu_addr[31:24];

  // NOTE: the entry storage has no reset; count and pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      defer         <= 1'b0;
      bus.cpu_ready <= 1'b0;
      bus.cpu_rdata <= '0;
    end else begin
      if (ctrl_wr) defer <= bus.cpu_wdata[0];
      bus.cpu_ready <= accept;
      bus.cpu_rdata <= (accept && is_ctrl && !is_write) ? status : 32'h0;
    end
  end

  // A pop on a flush edge is still issued; only the remaining entries are discarded.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.iomem_valid <= 1'b0;
      bus.iomem_addr  <= '0;
      bus.iomem_wdata <= '0;
      bus.iomem_wstrb <= '0;
    end else begin
      bus.iomem_valid <= pop;
      if (pop) begin
        bus.iomem_addr  <= {8'h0, head.addr};
        bus.iomem_wdata <= head.data;
        bus.iomem_wstrb <= head.strb;
      end
    end
  end

endmodule

// File: tb/tb_video_write_queue.sv
// Scoreboard bench for video_write_queue: bus writes push expected replays, the iomem monitor pops and compares.
module tb_video_write_queue;

  localparam int DEPTH = 16;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic vga_vsync = 1'b1;

  video_write_queue_if vif ();

  video_write_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .vga_vsync (vga_vsync),
    .bus       (vif.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int issued = 0;
  int issue_cyc[$];
  exp_t sb[$];

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Replays seen on the video port are compared in order against the scoreboard.
  always @(negedge clk) begin
    if (resetn && vif.iomem_valid) begin
      issued++;
      issue_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        check("unexpected_issue", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("iomem_addr", vif.iomem_addr, e.addr);
        check("iomem_wdata", vif.iomem_wdata, e.data);
        check("iomem_wstrb", {28'h0, vif.iomem_wstrb}, {28'h0, e.strb});
      end
    end
  end

  function automatic logic [31:0] status_model(input bit d, input int cnt, input bit vs);
    bit drain;
    drain = !d || !vs;
    return {16'h0, 8'(cnt), 4'h0, drain, (cnt == DEPTH), (cnt == 0), d};
  endfunction

  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] r, output int ack_cyc);
    int n = 0;
    @(posedge clk); #1;
    vif.cpu_valid = 1'b1;
    vif.cpu_addr  = a;
    vif.cpu_wdata = d;
    vif.cpu_wstrb = s;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!vif.cpu_ready && n < 200);
    r       = vif.cpu_rdata;
    ack_cyc = cyc;
    if (!vif.cpu_ready) check("bus_timeout", 32'd0, 32'd1);
    else if (s != 4'h0 && a[23:20] != 4'hF) sb.push_back('{{8'h0, a[23:0]}, d, s});
    vif.cpu_valid = 1'b0;
  endtask

  task automatic vwrite(input int i);
    logic [31:0] r;
    int c;
    bus(32'hAB30_0000 | 32'(i * 4), 32'hC0DE_0000 + 32'(i), 4'(i % 15 + 1), r, c);
  endtask

  task automatic ctrl(input logic [31:0] d);
    logic [31:0] r;
    int c;
    bus(32'h00F0_0000, d, 4'h1, r, c);
  endtask

  task automatic status_expect(input string tag, input logic [31:0] exp);
    logic [31:0] r;
    int c;
    bus(32'h00F0_0000, 32'h0, 4'h0, r, c);
    check(tag, r, exp);
  endtask

  task automatic wait_issued(input string tag, input int target);
    int n = 0;
    while (issued < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(issued), 32'(target));
  endtask

  int base;
  int ack17_cyc;
  bit acked17;
  logic [31:0] rd;
  int c;

  initial begin
    vif.cpu_valid = 1'b0;
    vif.cpu_addr  = '0;
    vif.cpu_wdata = '0;
    vif.cpu_wstrb = '0;

    // Reset state
    #12;
    check("rst_ready", {31'h0, vif.cpu_ready}, 32'h0);
    check("rst_rdata", vif.cpu_rdata, 32'h0);
    check("rst_valid", {31'h0, vif.iomem_valid}, 32'h0);
    check("rst_iaddr", vif.iomem_addr, 32'h0);
    check("rst_idata", vif.iomem_wdata, 32'h0);
    @(negedge clk); resetn = 1'b1;
    status_expect("status_after_reset", status_model(0, 0, 1));

    // Immediate mode write latency
    bus(32'hFF30_0008, 32'h1234_5678, 4'hF, rd, c);
    @(negedge clk); check("lat_not_yet", {31'h0, vif.iomem_valid}, 32'h0);
    @(negedge clk); check("lat_issue", {31'h0, vif.iomem_valid}, 32'h1);
    check("lat_addr", vif.iomem_addr, 32'h0030_0008);
    @(negedge clk); check("lat_one_cycle", {31'h0, vif.iomem_valid}, 32'h0);
    status_expect("status_immediate", status_model(0, 0, 1));

    // Deferred: five writes held until vsync
    ctrl(32'h1);
    base = issued;
    for (int i = 1; i <= 5; i++)
      bus(32'h0010_0000 + 32'(i * 4), 32'(i), 4'hF, rd, c);
    repeat (3) @(posedge clk);
    check("defer_hold", 32'(issued), 32'(base));
    status_expect("status_defer5", status_model(1, 5, 1));
    issue_cyc.delete();
    @(posedge clk); #1 vga_vsync = 1'b0;
    wait_issued("defer_drain5", base + 5);
    check("drain_back_to_back", 32'(issue_cyc[4] - issue_cyc[0]), 32'd4);
    status_expect("status_drained_vs_low", status_model(1, 0, 0));
    @(posedge clk); #1 vga_vsync = 1'b1;

    // Fill to DEPTH, then a stalled write
    base = issued;
    for (int i = 0; i < DEPTH; i++) vwrite(100 + i);
    status_expect("status_full", status_model(1, DEPTH, 1));
    bus(32'h0030_0000, 32'hDEAD_BEEF, 4'h0, rd, c);
    check("video_read_zero", rd, 32'h0);
    issue_cyc.delete();
    acked17 = 1'b0;
    fork
      begin
        bus(32'h0020_0040, 32'h0000_0017, 4'h3, rd, ack17_cyc);
        acked17 = 1'b1;
      end
      begin
        repeat (6) @(posedge clk);
        #2;
        check("stall_no_ack", {31'h0, acked17}, 32'h0);
        check("stall_ready_low", {31'h0, vif.cpu_ready}, 32'h0);
        vga_vsync = 1'b0;
      end
    join
    check("stall_ack_after_pop", {31'h0, (ack17_cyc > issue_cyc[0]) && (ack17_cyc - issue_cyc[0] <= 2)}, 32'h1);
    wait_issued("stall_drain17", base + DEPTH + 1);
    @(posedge clk); #1 vga_vsync = 1'b1;

    // Vsync window of exactly four edges
    base = issued;
    for (int i = 0; i < 10; i++) vwrite(200 + i);
    status_expect("status_ten", status_model(1, 10, 1));
    @(posedge clk); #1 vga_vsync = 1'b0;
    repeat (4) @(posedge clk);
    #1 vga_vsync = 1'b1;
    repeat (4) @(negedge clk);
    check("window_issued4", 32'(issued - base), 32'd4);
    status_expect("status_six_left", status_model(1, 6, 1));
    @(posedge clk); #1 vga_vsync = 1'b0;
    wait_issued("window_rest", base + 10);
    @(posedge clk); #1 vga_vsync = 1'b1;

    // Flush discards queued entries
    for (int i = 0; i < 4; i++) vwrite(300 + i);
    status_expect("status_four", status_model(1, 4, 1));
    ctrl(32'h3);
    sb.delete();
    status_expect("status_flushed", status_model(1, 0, 1));
    base = issued;
    @(posedge clk); #1 vga_vsync = 1'b0;
    repeat (10) @(negedge clk);
    check("flush_no_issue", 32'(issued), 32'(base));
    vwrite(400);
    wait_issued("post_flush_issue", base + 1);
    @(posedge clk); #1 vga_vsync = 1'b1;

    // Asynchronous reset in the middle of a drain
    for (int i = 0; i < 4; i++) vwrite(500 + i);
    @(posedge clk); #1 vga_vsync = 1'b0;
    begin
      int n = 0;
      while (!vif.iomem_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    check("mid_drain_active", {31'h0, vif.iomem_valid}, 32'h1);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_valid", {31'h0, vif.iomem_valid}, 32'h0);
    check("async_rst_addr", vif.iomem_addr, 32'h0);
    check("async_rst_strb", {28'h0, vif.iomem_wstrb}, 32'h0);
    sb.delete();
    vga_vsync = 1'b1;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    status_expect("status_after_rst2", status_model(0, 0, 1));
    repeat (4) @(negedge clk);
    check("sb_empty_end", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
